// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only instruction cache; hits return the same cycle,
// misses refill the whole line in word order over a ready-handshake memory port.
module instruction_cache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] program_counter_address,
    output logic [31:0] instruction,
    output logic        instruction_grant,
    input  logic        invalidate,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 30 - OW - IW;

    typedef enum logic {IDLE, REFILL} state_e;

    state_e               state_q, state_d;
    logic [OW-1:0]        beat_q, beat_d;
    logic [TW-1:0]        miss_tag_q, miss_tag_d;
    logic [IW-1:0]        miss_idx_q, miss_idx_d;
    logic                 inv_pend_q, inv_pend_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    logic [OW-1:0] pc_word;
    logic [IW-1:0] pc_idx;
    logic [TW-1:0] pc_tag;
    logic          unused_pc_bits;
    logic          hit, beat_ok, last_beat;

    assign pc_word        = program_counter_address[OW+1:2];
    assign pc_idx         = program_counter_address[OW+2 +: IW];
    assign pc_tag         = program_counter_address[31 -: TW];
    assign unused_pc_bits = ^program_counter_address[1:0];

    assign hit       = state_q == IDLE && valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
    assign beat_ok   = state_q == REFILL && mem_ready;
    assign last_beat = beat_ok && beat_q == OW'(LINE_WORDS - 1);

    assign instruction_grant = hit;
    assign instruction       = data_q[pc_idx][pc_word];
    assign mem_request       = state_q == REFILL;
    assign mem_address       = mem_request ? {miss_tag_q, miss_idx_q, beat_q, 2'b00} : '0;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        inv_pend_d = inv_pend_q;
        valid_d    = invalidate ? '0 : valid_q;
        if (state_q == IDLE) begin
            if (!hit) begin
                state_d    = REFILL;
                miss_tag_d = pc_tag;
                miss_idx_d = pc_idx;
                beat_d     = '0;
            end
        end else begin
            inv_pend_d = inv_pend_q | invalidate;
            beat_d     = beat_ok ? beat_q + 1'b1 : beat_q;
            // an invalidate seen at any point of the refill keeps the new line invalid
            if (last_beat) begin
                state_d    = IDLE;
                inv_pend_d = 1'b0;
                if (!inv_pend_q && !invalidate) valid_d[miss_idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            inv_pend_q <= inv_pend_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_ok) data_q[miss_idx_q][beat_q] <= mem_read_data;
        if (last_beat) tag_q[miss_idx_q] <= miss_tag_q;
    end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed test-plan steps plus random fetches checked against a
// line-address model of the cache and a constant memory image.
module tb_instruction_cache;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] pc = '0;
    logic        inv = 1'b0, ready = 1'b0;
    logic [31:0] instr, maddr, rdata;
    logic        grant, req;

    always #5 clk = ~clk;

    instruction_cache dut (
        .clk(clk), .rst(rst), .program_counter_address(pc), .instruction(instr),
        .instruction_grant(grant), .invalidate(inv), .mem_request(req),
        .mem_address(maddr), .mem_ready(ready), .mem_read_data(rdata)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11111111;
            32'h104: return 32'h22222222;
            32'h108: return 32'h33333333;
            32'h10C: return 32'h44444444;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
        endcase
    endfunction

    assign rdata = memfn(maddr);

    // model: which 16-byte line base each index holds, plus the refill in flight
    bit          lv[64];
    logic [31:0] lb[64];
    bit          rf, pend;
    logic [31:0] rbase;
    int          beats;
    int          checks = 0, passed = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (lv[k]) lv[k] = 1'b0;
        rf = 1'b0;
        pend = 1'b0;
        beats = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_req", {31'b0, req}, 32'h0);
        check("rst_addr", maddr, 32'h0);
        check("rst_grant", {31'b0, grant}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc(input logic [31:0] p, input logic i, input logic r);
        int idx;
        bit hit;
        pc = p;
        inv = i;
        ready = r;
        @(negedge clk);
        idx = (p >> 4) & 63;
        hit = !rf && lv[idx] && lb[idx] == (p & ~32'hF);
        check("grant", {31'b0, grant}, {31'b0, hit});
        if (hit) check("instr", instr, memfn(p & ~32'h3));
        check("req", {31'b0, req}, {31'b0, rf});
        check("addr", maddr, rf ? rbase + 32'(4 * beats) : 32'h0);
        if (i) foreach (lv[k]) lv[k] = 1'b0;
        if (rf) begin
            if (r) begin
                beats++;
                if (beats == 4) begin
                    if (!pend && !i) begin
                        lv[(rbase >> 4) & 63] = 1'b1;
                        lb[(rbase >> 4) & 63] = rbase;
                    end
                    rf = 1'b0;
                    pend = 1'b0;
                end
            end
            if (rf && i) pend = 1'b1;
        end else if (!hit) begin
            rf = 1'b1;
            rbase = p & ~32'hF;
            beats = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit bp[7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [31:0] p;
        #2 do_reset();
        // cold miss, then a 0-cycle hit on the last word
        repeat (6) cyc(32'h100, 0, 1);
        cyc(32'h10C, 0, 1);
        // conflict eviction on index 0
        repeat (6) cyc(32'h000, 0, 1);
        repeat (6) cyc(32'h400, 0, 1);
        repeat (6) cyc(32'h000, 0, 1);
        // memory back-pressure
        cyc(32'h400, 0, 1);
        foreach (bp[k]) cyc(32'h400, 0, bp[k]);
        cyc(32'h400, 0, 0);
        // invalidate a cached line
        cyc(32'h100, 0, 0);
        cyc(32'h100, 1, 0);
        repeat (6) cyc(32'h100, 0, 1);
        // invalidate mid-refill forces a second refill
        repeat (2) cyc(32'h500, 0, 1);
        cyc(32'h500, 1, 1);
        repeat (8) cyc(32'h500, 0, 1);
        // reset after two beats
        repeat (3) cyc(32'h600, 0, 1);
        do_reset();
        repeat (6) cyc(32'h600, 0, 1);
        // PC change during refill
        cyc(32'h200, 0, 1);
        repeat (10) cyc(32'h300, 0, 1);
        cyc(32'h200, 0, 1);
        // random fetches over a small conflicting address pool
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            p = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) |
                ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            cyc(p, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
